// File: rtl/zap_wb_walk_arbiter.sv
// Shares one registered Wishbone master port between the D-side (master 0) and
// I-side (master 1) page-table walkers with round-robin grants and an ack timeout.
module zap_wb_walk_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_m0_cyc_nxt,
    input  logic        i_m0_stb_nxt,
    input  logic [31:0] i_m0_adr_nxt,
    input  logic        i_m0_wen_nxt,
    input  logic [3:0]  i_m0_sel_nxt,
    input  logic [31:0] i_m0_dat_nxt,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic [31:0] o_m0_dat,

    input  logic        i_m1_cyc_nxt,
    input  logic        i_m1_stb_nxt,
    input  logic [31:0] i_m1_adr_nxt,
    input  logic        i_m1_wen_nxt,
    input  logic [3:0]  i_m1_sel_nxt,
    input  logic [31:0] i_m1_dat_nxt,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m1_dat,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_wen,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_dat,

    output logic [1:0]  o_owner
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_served;
    logic          last_served_nxt;
    logic [CW-1:0] tmo_cnt;
    logic          timeout;

    // The limit cycle only aborts when memory stays silent; a same-cycle ack wins.
    assign timeout = (tmo_cnt == CNT_LIMIT) && o_wb_stb && !i_wb_ack;

    always_comb begin
        state_nxt       = state;
        last_served_nxt = last_served;
        case (state)
            IDLE: begin
                if (i_m0_cyc_nxt && i_m1_cyc_nxt) begin
                    state_nxt       = last_served ? GNT0 : GNT1;
                    last_served_nxt = !last_served;
                end else if (i_m0_cyc_nxt) begin
                    state_nxt       = GNT0;
                    last_served_nxt = 1'b0;
                end else if (i_m1_cyc_nxt) begin
                    state_nxt       = GNT1;
                    last_served_nxt = 1'b1;
                end
            end
            GNT0: if (!i_m0_cyc_nxt || timeout) state_nxt = IDLE;
            GNT1: if (!i_m1_cyc_nxt || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
        end else begin
            state       <= state_nxt;
            last_served <= last_served_nxt;
        end
    end

    // Every grant passes through IDLE, so cyc always drops for a cycle between owners.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_wen <= 1'b0;
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_sel <= '0;
            o_owner  <= 2'b00;
            o_m0_err <= 1'b0;
            o_m1_err <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            o_m0_err <= (state == GNT0) && i_m0_cyc_nxt && timeout;
            o_m1_err <= (state == GNT1) && i_m1_cyc_nxt && timeout;
            o_owner  <= {state_nxt == GNT1, state_nxt == GNT0};

            if ((state_nxt != state) || i_wb_ack)
                tmo_cnt <= '0;
            else if (o_wb_stb && (tmo_cnt != CNT_MAX))
                tmo_cnt <= tmo_cnt + CW'(1);

            case (state_nxt)
                GNT0: begin
                    o_wb_cyc <= i_m0_cyc_nxt;
                    o_wb_stb <= i_m0_stb_nxt;
                    o_wb_wen <= i_m0_wen_nxt;
                    o_wb_adr <= i_m0_adr_nxt;
                    o_wb_dat <= i_m0_dat_nxt;
                    o_wb_sel <= i_m0_sel_nxt;
                end
                GNT1: begin
                    o_wb_cyc <= i_m1_cyc_nxt;
                    o_wb_stb <= i_m1_stb_nxt;
                    o_wb_wen <= i_m1_wen_nxt;
                    o_wb_adr <= i_m1_adr_nxt;
                    o_wb_dat <= i_m1_dat_nxt;
                    o_wb_sel <= i_m1_sel_nxt;
                end
                default: begin
                    o_wb_cyc <= 1'b0;
                    o_wb_stb <= 1'b0;
                end
            endcase
        end
    end

    assign o_m0_ack = i_wb_ack & (state == GNT0) & o_wb_stb;
    assign o_m1_ack = i_wb_ack & (state == GNT1) & o_wb_stb;
    assign o_m0_dat = i_wb_dat;
    assign o_m1_dat = i_wb_dat;

endmodule

// File: tb/tb_zap_wb_walk_arbiter.sv
// Bench for zap_wb_walk_arbiter: directed scenarios plus randomized walker traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_zap_wb_walk_arbiter;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  w_cyc;
    logic [1:0]  w_stb;
    logic [1:0]  w_wen;
    logic [31:0] w_adr [2];
    logic [3:0]  w_sel [2];
    logic [31:0] w_dat [2];
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_dat, m1_dat;
    logic        wb_cyc, wb_stb, wb_wen;
    logic [31:0] wb_adr, wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic [31:0] wb_rdat;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    zap_wb_walk_arbiter #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cyc_nxt(w_cyc[0]), .i_m0_stb_nxt(w_stb[0]), .i_m0_adr_nxt(w_adr[0]),
        .i_m0_wen_nxt(w_wen[0]), .i_m0_sel_nxt(w_sel[0]), .i_m0_dat_nxt(w_dat[0]),
        .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_dat(m0_dat),
        .i_m1_cyc_nxt(w_cyc[1]), .i_m1_stb_nxt(w_stb[1]), .i_m1_adr_nxt(w_adr[1]),
        .i_m1_wen_nxt(w_wen[1]), .i_m1_sel_nxt(w_sel[1]), .i_m1_dat_nxt(w_dat[1]),
        .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_dat(m1_dat),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_wen(wb_wen),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel),
        .i_wb_ack(wb_ack), .i_wb_dat(wb_rdat), .o_owner(owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner 0 = none, 1 = master0, 2 = master1.
    int        m_owner, m_last, m_cnt;
    bit        m_cyc, m_stb, m_wen;
    bit [31:0] m_adr, m_dat;
    bit [3:0]  m_sel;
    bit        m_err [2];

    int pending [2];
    int lat, age, cyc_no, first_stb, err_cyc, prev_owner;
    bit rand_lat, force_ack;
    int acks [2];
    int errs [2];
    int grants [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_txn(input int x);
        w_adr[x] = $urandom;
        w_wen[x] = 1'($urandom_range(0, 1));
        w_sel[x] = 4'($urandom);
        w_dat[x] = $urandom;
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 1; m_cnt = 0;
        m_cyc = 0; m_stb = 0; m_wen = 0; m_adr = 0; m_dat = 0; m_sel = 0;
        m_err[0] = 0; m_err[1] = 0;
    endtask

    task automatic clear_stats();
        acks[0] = 0; acks[1] = 0; errs[0] = 0; errs[1] = 0;
        grants.delete();
        first_stb = -1; err_cyc = -1;
    endtask

    // One bus cycle: memory and walkers react, outputs are checked, model and DUT advance.
    task automatic cycle();
        bit ack_seen [2];
        bit err_seen [2];
        int no, nl, nc;
        bit ncyc, nstb, nwen;
        bit [31:0] nadr, ndat;
        bit [3:0] nsel;
        bit ne [2];
        wb_ack  = force_ack || (wb_stb && (age == lat));
        wb_rdat = $urandom;
        #1;
        ack_seen[0] = m0_ack; ack_seen[1] = m1_ack;
        err_seen[0] = m0_err; err_seen[1] = m1_err;
        for (int x = 0; x < 2; x++) begin
            if ((ack_seen[x] || err_seen[x]) && pending[x] > 0) begin
                pending[x]--;
                new_txn(x);
            end
            w_cyc[x] = (pending[x] > 0) && !ack_seen[x] && !err_seen[x];
            w_stb[x] = w_cyc[x];
            acks[x] += int'(ack_seen[x]);
            errs[x] += int'(err_seen[x]);
        end
        #1;
        check("ack0", m0_ack, wb_ack && m_owner == 1 && m_stb);
        check("ack1", m1_ack, wb_ack && m_owner == 2 && m_stb);
        check("err0", m0_err, m_err[0]);
        check("err1", m1_err, m_err[1]);
        check("cyc", wb_cyc, m_cyc);
        check("stb", wb_stb, m_stb);
        check("owner", owner, m_owner);
        check("rdat", m0_dat ^ m1_dat ^ wb_rdat, wb_rdat);
        if (m_cyc) begin
            check("adr", wb_adr, m_adr);
            check("wdat", wb_dat, m_dat);
            check("sel", wb_sel, m_sel);
            check("wen", wb_wen, m_wen);
        end

        no = m_owner; nl = m_last; nc = m_cnt;
        ncyc = m_cyc; nstb = m_stb; nwen = m_wen; nadr = m_adr; ndat = m_dat; nsel = m_sel;
        ne[0] = 0; ne[1] = 0;
        if (rst) begin
            no = 0; nl = 1; nc = 0; ncyc = 0; nstb = 0; nwen = 0; nadr = 0; ndat = 0; nsel = 0;
        end else if (m_owner == 0) begin
            int win;
            win = -1;
            if (w_cyc[0] && w_cyc[1]) win = 1 - m_last;
            else if (w_cyc[0]) win = 0;
            else if (w_cyc[1]) win = 1;
            if (win >= 0) begin
                no = win + 1; nl = win; nc = 0;
                ncyc = w_cyc[win]; nstb = w_stb[win]; nwen = w_wen[win];
                nadr = w_adr[win]; ndat = w_dat[win]; nsel = w_sel[win];
            end else begin
                ncyc = 0; nstb = 0;
            end
        end else begin
            int x;
            x = m_owner - 1;
            if (!w_cyc[x]) begin
                no = 0; nc = 0; ncyc = 0; nstb = 0;
            end else if (m_cnt == T - 1 && m_stb && !wb_ack) begin
                no = 0; nc = 0; ncyc = 0; nstb = 0; ne[x] = 1; nl = x;
            end else begin
                ncyc = w_cyc[x]; nstb = w_stb[x]; nwen = w_wen[x];
                nadr = w_adr[x]; ndat = w_dat[x]; nsel = w_sel[x];
                if (wb_ack) nc = 0;
                else if (m_stb) nc = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
            end
        end

        if (wb_stb && !wb_ack) age++;
        else begin
            age = 0;
            if (rand_lat) lat = $urandom_range(0, 9);
        end
        @(posedge clk);
        #1;
        cyc_no++;
        m_owner = no; m_last = nl; m_cnt = nc;
        m_cyc = ncyc; m_stb = nstb; m_wen = nwen; m_adr = nadr; m_dat = ndat; m_sel = nsel;
        m_err[0] = ne[0]; m_err[1] = ne[1];
        if (owner != 2'b00 && prev_owner == 0) grants.push_back(int'(owner));
        prev_owner = int'(owner);
        if (wb_stb && first_stb < 0) first_stb = cyc_no;
        if (m1_err && err_cyc < 0) err_cyc = cyc_no;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((pending[0] > 0 || pending[1] > 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_pending", pending[0] + pending[1], 0);
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pending[0] = 0; pending[1] = 0;
        cycle();
        cycle();
        rst = 1'b0;
        age = 0;
    endtask

    initial begin
        rst = 1'b1; w_cyc = 0; w_stb = 0; wb_ack = 0; wb_rdat = 0;
        force_ack = 0; rand_lat = 0; lat = 2; age = 0; cyc_no = 0; prev_owner = 0;
        pending[0] = 0; pending[1] = 0;
        new_txn(0); new_txn(1);
        @(posedge clk);
        #1;
        model_reset();
        clear_stats();
        do_reset();
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_owner", owner, 2'b00);
        check("rst_adr", wb_adr, 32'h0);
        check("rst_err", {m0_err, m1_err}, 2'b00);

        // Lone D-walker read at 0x4000, memory acks two cycles after stb.
        clear_stats();
        lat = 2;
        w_adr[0] = 32'h0000_4000; w_wen[0] = 1'b0;
        pending[0] = 1;
        cycle();
        check("t1_cyc", wb_cyc, 1'b1);
        check("t1_adr", wb_adr, 32'h0000_4000);
        check("t1_owner", owner, 2'b01);
        drain(30);
        check("t1_acks0", acks[0], 1);
        check("t1_acks1", acks[1], 0);

        // Simultaneous requests after reset: m0 first, then m1.
        do_reset();
        clear_stats();
        pending[0] = 1; pending[1] = 1;
        drain(40);
        check("t2_ngrants", grants.size(), 2);
        if (grants.size() == 2) begin
            check("t2_first", grants[0], 1);
            check("t2_second", grants[1], 2);
        end

        // Continuous contention: grants alternate 0,1,0,1.
        do_reset();
        clear_stats();
        pending[0] = 2; pending[1] = 2;
        drain(60);
        check("t3_ngrants", grants.size(), 4);
        if (grants.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t3_order", grants[i], (i % 2) + 1);
        end

        // I-walker with a silent memory times out.
        clear_stats();
        lat = 1000;
        pending[1] = 1;
        drain(40);
        check("t4_err_delay", err_cyc - first_stb, T);
        check("t4_errs1", errs[1], 1);
        check("t4_acks", acks[0] + acks[1], 0);

        // Ack on the limit cycle beats the timeout.
        clear_stats();
        lat = T - 1;
        pending[1] = 1;
        drain(40);
        check("t5_acks1", acks[1], 1);
        check("t5_errs1", errs[1], 0);

        // Reset while m0 waits; a late ack must not reach either walker.
        clear_stats();
        lat = 1000;
        pending[0] = 1;
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        check("t6_cyc", wb_cyc, 1'b0);
        check("t6_owner", owner, 2'b00);
        rst = 1'b0;
        pending[0] = 0;
        force_ack = 1'b1;
        cycle();
        force_ack = 1'b0;
        check("t6_acks", acks[0] + acks[1], 0);
        repeat (2) cycle();

        // Randomized traffic with random latencies, some of which time out.
        rand_lat = 1'b1;
        lat = $urandom_range(0, 9);
        for (int r = 0; r < 8; r++) begin
            pending[0] = $urandom_range(0, 4);
            pending[1] = $urandom_range(1, 4);
            drain(600);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
